cache_tag_ctrl: RTL and testbench

//  Tag/replacement sequencer for the 4-way set-associative cache; sits directly upstream of lru_controller.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_tag_ctrl_if.sv | 23 ++
 rtl/cache_tag_store.sv | 61 ++++++
 rtl/cache_tag_ctrl.sv | 153 +++++++++++++++
 tb/tb_cache_tag_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the 4-way cache tag sequencer.
// Address split is {tag, index, offset} over a 16-byte line.
package cache_pkg;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 4;
    localparam int INDEX_W  = 7;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int NUM_SETS = 2 ** INDEX_W;
    localparam int NUM_WAYS = 4;

    typedef logic [NUM_WAYS-1:0] way_t;
    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [INDEX_W-1:0]  index_t;
    typedef logic [ADDR_W-1:0]   addr_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT,
        RESP
    } state_e;

    function automatic addr_t line_addr(tag_t tag, index_t index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

    function automatic way_t lowest_way(way_t v);
        return v & (~v + way_t'(1));
    endfunction
endpackage

// File: rtl/cache_tag_ctrl_if.sv
// CPU request/response bundle for the tag sequencer.
// master = requesting CPU side, slave = cache_tag_ctrl.
interface cache_tag_ctrl_if;
    import cache_pkg::*;

    logic  req_valid;
    logic  req_ready;
    addr_t req_addr;
    logic  req_write;
    logic  resp_valid;
    logic  resp_hit;
    way_t  resp_way;

    modport master (
        output req_valid, req_addr, req_write,
        input  req_ready, resp_valid, resp_hit, resp_way
    );

    modport slave (
        input  req_valid, req_addr, req_write,
        output req_ready, resp_valid, resp_hit, resp_way
    );
endinterface

// File: rtl/cache_tag_store.sv
// Valid/dirty/tag arrays for 128 sets x 4 ways with combinational
// readout of the addressed set and a per-way tag compare.
module cache_tag_store
    import cache_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  index_t                  index,
    input  tag_t                    cmp_tag,
    output way_t                    hit_vec,
    output way_t                    valid_vec,
    output way_t                    dirty_vec,
    output tag_t [NUM_WAYS-1:0]     rd_tag,
    input  logic                    install_en,
    input  logic                    set_dirty_en,
    input  way_t                    wr_way
);
    way_t                valid_q [NUM_SETS];
    way_t                valid_d [NUM_SETS];
    way_t                dirty_q [NUM_SETS];
    way_t                dirty_d [NUM_SETS];
    tag_t [NUM_WAYS-1:0] tag_q   [NUM_SETS];
    tag_t [NUM_WAYS-1:0] tag_d   [NUM_SETS];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        if (install_en) begin
            valid_d[index] = valid_q[index] | wr_way;
            dirty_d[index] = dirty_q[index] & ~wr_way;
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (wr_way[w]) tag_d[index][w] = cmp_tag;
            end
        end
        if (set_dirty_en) dirty_d[index] = dirty_d[index] | wr_way;
    end

    // Tags carry no reset: a tag is only meaningful behind its valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
        tag_q <= tag_d;
    end

    always_comb begin
        hit_vec = '0;
        rd_tag  = tag_q[index];
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid_q[index][w] && (tag_q[index][w] == cmp_tag);
        end
    end

    assign valid_vec = valid_q[index];
    assign dirty_vec = dirty_q[index];
endmodule

// File: rtl/cache_tag_ctrl.sv
// Tag/replacement sequencer: lookup, victim select, writeback, fill,
// then a one-cycle response with an LRU update strobe.
module cache_tag_ctrl
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    cache_tag_ctrl_if.slave  bus,
    output index_t           lru_index,
    input  way_t             lru_way_in,
    output way_t             lru_access_way,
    output logic             lru_update,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_write,
    output addr_t            mem_req_addr,
    input  logic             mem_done
);
    state_e state_q, state_d;
    tag_t   req_tag_q, req_tag_d;
    index_t req_index_q, req_index_d;
    logic   write_q, write_d;
    logic   hit_q, hit_d;
    way_t   way_q, way_d;
    tag_t   victim_tag_q, victim_tag_d;

    way_t                hit_vec, valid_vec, dirty_vec;
    tag_t [NUM_WAYS-1:0] rd_tag;
    way_t                hit_way, victim_way;
    tag_t                victim_tag_sel;
    logic                victim_dirty;
    logic                install_en, set_dirty_en;
    logic                unused_offset;

    assign unused_offset = ^bus.req_addr[OFFSET_W-1:0];

    cache_tag_store u_store (
        .clk          (clk),
        .reset        (reset),
        .index        (req_index_q),
        .cmp_tag      (req_tag_q),
        .hit_vec      (hit_vec),
        .valid_vec    (valid_vec),
        .dirty_vec    (dirty_vec),
        .rd_tag       (rd_tag),
        .install_en   (install_en),
        .set_dirty_en (set_dirty_en),
        .wr_way       (way_q)
    );

    // Invalid ways are free; only a full set defers to the LRU choice.
    always_comb begin
        hit_way        = lowest_way(hit_vec);
        victim_way     = (&valid_vec) ? lru_way_in : lowest_way(~valid_vec);
        victim_dirty   = |(victim_way & valid_vec & dirty_vec);
        victim_tag_sel = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (victim_way[w]) victim_tag_sel = rd_tag[w];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            req_tag_q    <= '0;
            req_index_q  <= '0;
            write_q      <= 1'b0;
            hit_q        <= 1'b0;
            way_q        <= '0;
            victim_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            req_tag_q    <= req_tag_d;
            req_index_q  <= req_index_d;
            write_q      <= write_d;
            hit_q        <= hit_d;
            way_q        <= way_d;
            victim_tag_q <= victim_tag_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_tag_d    = req_tag_q;
        req_index_d  = req_index_q;
        write_d      = write_q;
        hit_d        = hit_q;
        way_d        = way_q;
        victim_tag_d = victim_tag_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_tag_d   = bus.req_addr[ADDR_W-1 -: TAG_W];
                    req_index_d = bus.req_addr[OFFSET_W +: INDEX_W];
                    write_d     = bus.req_write;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d = |hit_vec;
                if (|hit_vec) begin
                    way_d   = hit_way;
                    state_d = RESP;
                end else begin
                    way_d        = victim_way;
                    victim_tag_d = victim_tag_sel;
                    state_d      = victim_dirty ? WB_REQ : FILL_REQ;
                end
            end
            WB_REQ:    if (mem_req_ready) state_d = WB_WAIT;
            WB_WAIT:   if (mem_done) state_d = FILL_REQ;
            FILL_REQ:  if (mem_req_ready) state_d = FILL_WAIT;
            FILL_WAIT: if (mem_done) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_hit   = hit_q;
        bus.resp_way   = way_q;
        lru_access_way = way_q;
        lru_update     = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_write  = 1'b0;
        mem_req_addr   = line_addr(req_tag_q, req_index_q);
        install_en     = 1'b0;
        set_dirty_en   = 1'b0;
        unique case (state_q)
            IDLE: bus.req_ready = 1'b1;
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = line_addr(victim_tag_q, req_index_q);
            end
            FILL_REQ:  mem_req_valid = 1'b1;
            FILL_WAIT: install_en = mem_done;
            RESP: begin
                bus.resp_valid = 1'b1;
                lru_update     = 1'b1;
                set_dirty_en   = write_q;
            end
            default: ;
        endcase
    end

    assign lru_index = req_index_q;

    a_single_hit: assert property (@(posedge clk) disable iff (reset)
        (state_q == LOOKUP) |-> $onehot0(hit_vec));
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Directed bench: expected responses and memory requests are queued by
// the stimulus and consumed by independent monitors.
module tb_cache_tag_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_tag_ctrl_if bus ();
    index_t lru_index;
    way_t   lru_way_in, lru_access_way;
    logic   lru_update;
    logic   mem_req_valid, mem_req_ready, mem_req_write;
    addr_t  mem_req_addr;
    logic   mem_done, done_r, spur_done;
    assign mem_done = done_r | spur_done;

    cache_tag_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .lru_index      (lru_index),
        .lru_way_in     (lru_way_in),
        .lru_access_way (lru_access_way),
        .lru_update     (lru_update),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_done       (mem_done)
    );

    typedef struct {
        logic        hit;
        way_t        way;
        index_t      index;
        logic        chk_lat;
        int unsigned acc;
    } resp_exp_t;

    typedef struct {
        logic  write;
        addr_t addr;
    } mem_exp_t;

    resp_exp_t   resp_q[$];
    mem_exp_t    mem_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          ready_delay = 1;
    int          done_delay = 2;
    logic        drop_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: ready after ready_delay cycles, done pulse later.
    initial begin
        mem_req_ready = 1'b0;
        done_r = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mem_req_valid) begin
                repeat (ready_delay) begin @(posedge clk); #1; end
                mem_req_ready = 1'b1;
                @(posedge clk); #1;
                mem_req_ready = 1'b0;
                repeat (done_delay) begin @(posedge clk); #1; end
                if (!drop_done) done_r = 1'b1;
                @(posedge clk); #1;
                done_r = 1'b0;
            end
        end
    end

    resp_exp_t re;
    always @(negedge clk) begin
        if (!reset && bus.resp_valid) begin
            if (resp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got way %0h expected none",
                         bus.resp_way);
            end else begin
                re = resp_q.pop_front();
                check("resp_hit", 64'(bus.resp_hit), 64'(re.hit));
                check("resp_way", 64'(bus.resp_way), 64'(re.way));
                check("lru_update", 64'(lru_update), 64'd1);
                check("lru_access_way", 64'(lru_access_way), 64'(re.way));
                check("lru_index", 64'(lru_index), 64'(re.index));
                if (re.chk_lat) check("hit_latency", 64'(cyc - re.acc), 64'd2);
            end
        end
    end

    mem_exp_t me;
    logic     pv = 1'b0, ph = 1'b0, pw = 1'b0;
    addr_t    pa = '0;
    always @(negedge clk) begin
        if (reset) begin
            pv = 1'b0;
            ph = 1'b0;
        end else begin
            if (mem_req_valid && pv && !ph) begin
                check("mem_hold_addr", 64'(mem_req_addr), 64'(pa));
                check("mem_hold_write", 64'(mem_req_write), 64'(pw));
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_mem_req: got addr %0h expected none",
                             mem_req_addr);
                end else begin
                    me = mem_q.pop_front();
                    check("mem_req_write", 64'(mem_req_write), 64'(me.write));
                    check("mem_req_addr", 64'(mem_req_addr), 64'(me.addr));
                end
            end
            pv = mem_req_valid;
            pa = mem_req_addr;
            pw = mem_req_write;
            ph = mem_req_valid && mem_req_ready;
        end
    end

    task automatic issue(addr_t a, logic wr, logic hit, way_t way,
                         logic lat, logic expect_resp);
        int n;
        int unsigned acc;
        index_t idx;
        n = 0;
        idx = a[OFFSET_W +: INDEX_W];
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check("req_ready_wait", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_write = wr;
        @(posedge clk);
        acc = cyc;
        if (expect_resp) resp_q.push_back('{hit, way, idx, lat, acc});
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || mem_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("txn_complete", 64'(resp_q.size() + mem_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic read_miss(addr_t a, way_t way);
        mem_q.push_back('{1'b0, {a[ADDR_W-1:OFFSET_W], 4'h0}});
        issue(a, 1'b0, 1'b0, way, 1'b0, 1'b1);
        wait_done();
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_write = 1'b0;
        lru_way_in    = 4'b0001;
        spur_done     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_lru_update", 64'(lru_update), 64'd0);

        // Cold miss, then hit on the same line.
        read_miss(32'h0000_1230, 4'b0001);
        issue(32'h0000_1234, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1);
        wait_done();

        // Fill remaining ways of set 0x23, then LRU-chosen clean victim.
        read_miss(32'h0000_1A30, 4'b0010);
        read_miss(32'h0000_2230, 4'b0100);
        read_miss(32'h0000_2A30, 4'b1000);
        lru_way_in = 4'b0100;
        read_miss(32'h0000_3230, 4'b0100);

        // Dirty the way, then evict it under a slow memory.
        issue(32'h0000_3234, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1);
        wait_done();
        ready_delay = 5;
        mem_q.push_back('{1'b1, 32'h0000_3230});
        mem_q.push_back('{1'b0, 32'h0000_3A30});
        issue(32'h0000_3A30, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1);
        wait_done();
        ready_delay = 1;

        // Stray done while idle must be ignored.
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        check("spur_req_ready", 64'(bus.req_ready), 64'd1);
        check("spur_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("spur_resp_valid", 64'(bus.resp_valid), 64'd0);
        issue(32'h0000_3A34, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1);
        wait_done();
        issue(32'h0000_1A34, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1);
        wait_done();

        // Reset while waiting for the fill to complete.
        lru_way_in = 4'b0001;
        done_delay = 3;
        drop_done  = 1'b1;
        mem_q.push_back('{1'b0, 32'h0000_4230});
        issue(32'h0000_4230, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0);
        n = 0;
        while (!(mem_req_valid && mem_req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("fill_handshake_seen", 64'(mem_req_valid && mem_req_ready), 64'd1);
        @(negedge clk);
        check("fill_wait_req_ready", 64'(bus.req_ready), 64'd0);
        check("fill_wait_mem_valid", 64'(mem_req_valid), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        check("midrst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        repeat (8) @(negedge clk);
        drop_done  = 1'b0;
        done_delay = 2;
        check("midrst_mem_q_drained", 64'(mem_q.size()), 64'd0);
        read_miss(32'h0000_3A34, 4'b0001);

        check("final_resp_q_empty", 64'(resp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
